// File: rtl/voice_allocator_if.sv
// Note-event handshake between the MIDI decoder (master) and voice_allocator (slave).
//   ev_valid : event offered
//   ev_ready : event accepted when ev_valid & ev_ready
//   ev_on    : 1 = note-on, 0 = note-off
//   ev_key   : MIDI key number (bit7 ignored)
//   ev_vel   : velocity (bit7 ignored)
interface voice_allocator_if;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [7:0] ev_key;
    logic [7:0] ev_vel;

    modport master (output ev_valid, ev_on, ev_key, ev_vel, input ev_ready);
    modport slave  (input ev_valid, ev_on, ev_key, ev_vel, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: assigns MIDI note events to synth_engine voice slots, one event at a time.
// An accepted event is scanned against every voice (one voice per cycle), committed for one
// cycle, and followed by one retire cycle before the next event can be accepted.
//
// Optional build macro: VOICE_STEAL_EN
//   defined   : a note-on with no same-key or free voice steals the oldest voice
//               (released voices first, then held ones); per-voice age counters are built.
//   undefined : no age tables; such a note-on is dropped silently.
//
// Ports
//   reg_clk, reset_reg_n : clock (rising edge) and asynchronous active-low reset
//   ev                   : note event handshake (slave side); ev_ready is combinational
//                          (IDLE and no all_off this cycle)
//   all_off              : clears every held key (panic), wins over a pending event
//   voice_free           : per-voice "envelope fully released"
//   note_on              : 1-cycle strobe, an allocation or release was committed
//   cur_key_adr/_val     : voice index and key of the last committed event
//   cur_vel_on/_off      : velocity of the last committed note-on / note-off
//   keys_on              : per-voice key-held flags
//   active_keys          : popcount of keys_on, one cycle behind
//   off_note_error       : 1-cycle strobe, note-off matched no held voice
module voice_allocator #(
    parameter int unsigned VOICES  = 32,
    parameter int unsigned V_WIDTH = $clog2(VOICES),
    parameter int unsigned AGE_W   = 8
) (
    input  logic                 reg_clk,
    input  logic                 reset_reg_n,
    voice_allocator_if.slave     ev,
    input  logic                 all_off,
    input  logic [VOICES-1:0]    voice_free,
    output logic                 note_on,
    output logic [V_WIDTH-1:0]   cur_key_adr,
    output logic [7:0]           cur_key_val,
    output logic [7:0]           cur_vel_on,
    output logic [7:0]           cur_vel_off,
    output logic [VOICES-1:0]    keys_on,
    output logic [V_WIDTH:0]     active_keys,
    output logic                 off_note_error
);
    localparam int unsigned CNT_W = V_WIDTH + 1;
    localparam logic [V_WIDTH-1:0] LAST_IDX = V_WIDTH'(VOICES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RETIRE} state_t;

    state_t             state;
    logic [V_WIDTH-1:0] idx;
    logic               lat_on;
    logic [7:0]         lat_key;
    logic [7:0]         lat_vel;
    logic [7:0]         key_tbl [VOICES];

    logic               same_fnd;
    logic [V_WIDTH-1:0] same_idx;
    logic               free_fnd;
    logic [V_WIDTH-1:0] free_idx;

`ifdef VOICE_STEAL_EN
    logic [AGE_W-1:0]   age_tbl [VOICES];
    logic               rel_fnd;
    logic [V_WIDTH-1:0] rel_idx;
    logic [AGE_W-1:0]   rel_age;
    logic               held_fnd;
    logic [V_WIDTH-1:0] held_idx;
    logic [AGE_W-1:0]   held_age;
`endif

    logic               hit_c;
    logic               free_c;
    logic               tgt_ok_c;
    logic [V_WIDTH-1:0] tgt_idx_c;

    function automatic logic [CNT_W-1:0] popcount(input logic [VOICES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(VOICES); i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Event handshake: only in IDLE, and a panic this cycle blocks acceptance.
    assign ev.ev_ready = (state == IDLE) && !all_off;

    // Per-voice scan predicates for the voice under examination.
    assign hit_c  = keys_on[idx] && (key_tbl[idx] == lat_key);
    assign free_c = !keys_on[idx] && voice_free[idx];

    // Note-on target: same key > free voice > (optionally) oldest voice.
    always_comb begin
        tgt_ok_c  = 1'b0;
        tgt_idx_c = '0;
        if (same_fnd) begin
            tgt_ok_c  = 1'b1;
            tgt_idx_c = same_idx;
        end else if (free_fnd) begin
            tgt_ok_c  = 1'b1;
            tgt_idx_c = free_idx;
        end
`ifdef VOICE_STEAL_EN
        else if (rel_fnd) begin
            tgt_ok_c  = 1'b1;
            tgt_idx_c = rel_idx;
        end else if (held_fnd) begin
            tgt_ok_c  = 1'b1;
            tgt_idx_c = held_idx;
        end
`endif
    end

    // Allocation FSM with registered outputs.
    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            state          <= IDLE;
            idx            <= '0;
            lat_on         <= 1'b0;
            lat_key        <= '0;
            lat_vel        <= '0;
            same_fnd       <= 1'b0;
            same_idx       <= '0;
            free_fnd       <= 1'b0;
            free_idx       <= '0;
            note_on        <= 1'b0;
            off_note_error <= 1'b0;
            cur_key_adr    <= '0;
            cur_key_val    <= '0;
            cur_vel_on     <= '0;
            cur_vel_off    <= '0;
            keys_on        <= '0;
            active_keys    <= '0;
            for (int i = 0; i < int'(VOICES); i++) begin
                key_tbl[i] <= '0;
            end
`ifdef VOICE_STEAL_EN
            for (int i = 0; i < int'(VOICES); i++) begin
                age_tbl[i] <= '0;
            end
            rel_fnd  <= 1'b0;
            rel_idx  <= '0;
            rel_age  <= '0;
            held_fnd <= 1'b0;
            held_idx <= '0;
            held_age <= '0;
`endif
        end else begin
            note_on        <= 1'b0;
            off_note_error <= 1'b0;
            active_keys    <= popcount(keys_on);

            case (state)
                IDLE: begin
                    if (all_off) begin
                        keys_on <= '0;
                    end else if (ev.ev_valid) begin
                        // A zero-velocity note-on is a note-off with release velocity 64.
                        lat_on   <= ev.ev_on && (ev.ev_vel[6:0] != 7'd0);
                        lat_key  <= ev.ev_key & 8'h7F;
                        lat_vel  <= (ev.ev_on && (ev.ev_vel[6:0] == 7'd0)) ? 8'd64
                                                                            : (ev.ev_vel & 8'h7F);
                        idx      <= '0;
                        same_fnd <= 1'b0;
                        free_fnd <= 1'b0;
`ifdef VOICE_STEAL_EN
                        rel_fnd  <= 1'b0;
                        held_fnd <= 1'b0;
`endif
                        state    <= SCAN;
                    end
                end

                SCAN: begin
                    if (hit_c && !same_fnd) begin
                        same_fnd <= 1'b1;
                        same_idx <= idx;
                    end
                    if (lat_on && free_c && !free_fnd) begin
                        free_fnd <= 1'b1;
                        free_idx <= idx;
                    end
`ifdef VOICE_STEAL_EN
                    // Strict compare keeps the lowest index on equal ages.
                    if (lat_on) begin
                        if (!keys_on[idx]) begin
                            if (!rel_fnd || (age_tbl[idx] > rel_age)) begin
                                rel_fnd <= 1'b1;
                                rel_idx <= idx;
                                rel_age <= age_tbl[idx];
                            end
                        end else if (!held_fnd || (age_tbl[idx] > held_age)) begin
                            held_fnd <= 1'b1;
                            held_idx <= idx;
                            held_age <= age_tbl[idx];
                        end
                    end
`endif
                    if (idx == LAST_IDX) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + V_WIDTH'(1);
                    end
                end

                COMMIT: begin
                    if (lat_on) begin
                        if (tgt_ok_c) begin
                            keys_on[tgt_idx_c] <= 1'b1;
                            key_tbl[tgt_idx_c] <= lat_key;
                            note_on            <= 1'b1;
                            cur_key_adr        <= tgt_idx_c;
                            cur_key_val        <= lat_key;
                            cur_vel_on         <= lat_vel;
`ifdef VOICE_STEAL_EN
                            for (int i = 0; i < int'(VOICES); i++) begin
                                if (V_WIDTH'(i) == tgt_idx_c) begin
                                    age_tbl[i] <= '0;
                                end else if (age_tbl[i] != {AGE_W{1'b1}}) begin
                                    age_tbl[i] <= age_tbl[i] + AGE_W'(1);
                                end
                            end
`endif
                        end
                    end else if (same_fnd) begin
                        keys_on[same_idx] <= 1'b0;
                        note_on           <= 1'b1;
                        cur_key_adr       <= same_idx;
                        cur_key_val       <= lat_key;
                        cur_vel_off       <= lat_vel;
                    end else begin
                        off_note_error <= 1'b1;
                    end
                    state <= RETIRE;
                end

                RETIRE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator (4 voices) with a strobe scoreboard.
`timescale 1ns/1ps
module tb_voice_allocator;
    localparam int unsigned VOICES  = 4;
    localparam int unsigned V_WIDTH = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               all_off;
    logic [VOICES-1:0]  voice_free;
    logic               note_on;
    logic [V_WIDTH-1:0] cur_key_adr;
    logic [7:0]         cur_key_val;
    logic [7:0]         cur_vel_on;
    logic [7:0]         cur_vel_off;
    logic [VOICES-1:0]  keys_on;
    logic [V_WIDTH:0]   active_keys;
    logic               off_note_error;

    voice_allocator_if ev_if ();

    always #5 clk = ~clk;

    voice_allocator #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .AGE_W(8)) dut (
        .reg_clk        (clk),
        .reset_reg_n    (rst_n),
        .ev             (ev_if),
        .all_off        (all_off),
        .voice_free     (voice_free),
        .note_on        (note_on),
        .cur_key_adr    (cur_key_adr),
        .cur_key_val    (cur_key_val),
        .cur_vel_on     (cur_vel_on),
        .cur_vel_off    (cur_vel_off),
        .keys_on        (keys_on),
        .active_keys    (active_keys),
        .off_note_error (off_note_error)
    );

    typedef struct packed {
        logic               err;
        logic [V_WIDTH-1:0] adr;
        logic [7:0]         key;
        logic [7:0]         von;
        logic [7:0]         voff;
    } exp_t;

    exp_t               q[$];
    int                 n_vec = 0;
    int                 n_err = 0;
    logic [V_WIDTH-1:0] m_adr = '0;
    logic [7:0]         m_key = '0;
    logic [7:0]         m_von = '0;
    logic [7:0]         m_voff = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected strobes; cur_* of an error strobe are the values held from the last commit.
    function automatic void exp_on(input logic [V_WIDTH-1:0] adr, input logic [7:0] key,
                                   input logic [7:0] vel);
        m_adr = adr; m_key = key; m_von = vel;
        q.push_back('{1'b0, m_adr, m_key, m_von, m_voff});
    endfunction

    function automatic void exp_off(input logic [V_WIDTH-1:0] adr, input logic [7:0] key,
                                    input logic [7:0] vel);
        m_adr = adr; m_key = key; m_voff = vel;
        q.push_back('{1'b0, m_adr, m_key, m_von, m_voff});
    endfunction

    function automatic void exp_err();
        q.push_back('{1'b1, m_adr, m_key, m_von, m_voff});
    endfunction

    // Monitor: compares every strobe against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (note_on || off_note_error)) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got note_on=%0b off_note_error=%0b, expected none",
                             note_on, off_note_error);
                end else begin
                    e = q.pop_front();
                    check("strobe",
                          32'({note_on, off_note_error, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off}),
                          32'({~e.err, e.err, e.adr, e.key, e.von, e.voff}));
                end
            end
        end
    end

    task automatic send(input logic on, input logic [7:0] key, input logic [7:0] vel);
        int t;
        @(negedge clk);
        ev_if.ev_valid = 1'b1;
        ev_if.ev_on    = on;
        ev_if.ev_key   = key;
        ev_if.ev_vel   = vel;
        t = 0;
        while (!ev_if.ev_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ev_if.ev_ready) begin
            check("accept_timeout", 32'(t), 32'(0));
            ev_if.ev_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 ev_if.ev_valid = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (VOICES + 4) @(negedge clk);
    endtask

    initial begin
        int t;
        all_off        = 1'b0;
        voice_free     = '1;
        ev_if.ev_valid = 1'b0;
        ev_if.ev_on    = 1'b0;
        ev_if.ev_key   = '0;
        ev_if.ev_vel   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_ev_ready", 32'(ev_if.ev_ready), 32'(1));
        check("rst_note_on", 32'(note_on), 32'(0));
        check("rst_off_err", 32'(off_note_error), 32'(0));
        check("rst_keys_on", 32'(keys_on), 32'(0));
        check("rst_active", 32'(active_keys), 32'(0));
        check("rst_adr", 32'(cur_key_adr), 32'(0));

        // First note-on, with accept-to-strobe latency
        exp_on(2'd0, 8'd60, 8'd100);
        send(1'b1, 8'd60, 8'd100);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!note_on && t < 20);
        check("latency", 32'(t), 32'(6));
        settle();
        check("t1_keys_on", 32'(keys_on), 32'b0001);
        check("t1_active", 32'(active_keys), 32'(1));

        // Two more note-ons, then release key 62
        exp_on(2'd1, 8'd62, 8'd90);
        send(1'b1, 8'd62, 8'd90);
        settle();
        exp_on(2'd2, 8'd64, 8'd80);
        send(1'b1, 8'd64, 8'd80);
        settle();
        check("t2_keys_3", 32'(keys_on), 32'b0111);
        exp_off(2'd1, 8'd62, 8'd40);
        send(1'b0, 8'd62, 8'd40);
        settle();
        check("t2_keys_on", 32'(keys_on), 32'b0101);
        check("t2_active", 32'(active_keys), 32'(2));

        // Retrigger of a held key reuses its voice
        exp_on(2'd0, 8'd60, 8'd110);
        send(1'b1, 8'd60, 8'd110);
        settle();
        check("t3_keys_on", 32'(keys_on), 32'b0101);

        // Zero-velocity note-on becomes an unmatched note-off
        exp_err();
        send(1'b1, 8'd67, 8'd0);
        settle();
        check("t4_keys_on", 32'(keys_on), 32'b0101);

        // Third held key, then panic together with a pending event
        exp_on(2'd1, 8'd65, 8'd70);
        send(1'b1, 8'd65, 8'd70);
        settle();
        check("t6_keys_3", 32'(keys_on), 32'b0111);
        check("t6_active_3", 32'(active_keys), 32'(3));
        @(negedge clk);
        all_off        = 1'b1;
        ev_if.ev_valid = 1'b1;
        ev_if.ev_on    = 1'b1;
        ev_if.ev_key   = 8'd72;
        ev_if.ev_vel   = 8'd50;
        #1 check("t6_ready_low", 32'(ev_if.ev_ready), 32'(0));
        exp_on(2'd0, 8'd72, 8'd50);
        @(negedge clk);
        check("t6_keys_clear", 32'(keys_on), 32'(0));
        all_off = 1'b0;
        #1 check("t6_ready_high", 32'(ev_if.ev_ready), 32'(1));
        @(posedge clk);
        #1 ev_if.ev_valid = 1'b0;
        settle();
        check("t6_keys_after", 32'(keys_on), 32'b0001);
        check("t6_active_after", 32'(active_keys), 32'(1));

        // Fill every voice, then note-on with nothing free
        @(negedge clk);
        all_off = 1'b1;
        @(negedge clk);
        all_off = 1'b0;
        check("t5_cleared", 32'(keys_on), 32'(0));
        exp_on(2'd0, 8'd60, 8'd1);
        send(1'b1, 8'd60, 8'd1);
        settle();
        exp_on(2'd1, 8'd62, 8'd2);
        send(1'b1, 8'd62, 8'd2);
        settle();
        exp_on(2'd2, 8'd64, 8'd3);
        send(1'b1, 8'd64, 8'd3);
        settle();
        exp_on(2'd3, 8'd65, 8'd4);
        send(1'b1, 8'd65, 8'd4);
        settle();
        check("t5_full", 32'(keys_on), 32'b1111);
        check("t5_active4", 32'(active_keys), 32'(4));
        voice_free = '0;
`ifdef VOICE_STEAL_EN
        exp_on(2'd0, 8'd70, 8'd99);
`endif
        send(1'b1, 8'd70, 8'd99);
        settle();
        check("t5_keys_steal", 32'(keys_on), 32'b1111);
        // Releasing key 70 shows whether it landed on voice 0
`ifdef VOICE_STEAL_EN
        exp_off(2'd0, 8'd70, 8'd5);
        send(1'b0, 8'd70, 8'd5);
        settle();
        check("t5_keys_rel", 32'(keys_on), 32'b1110);
`else
        exp_err();
        send(1'b0, 8'd70, 8'd5);
        settle();
        check("t5_keys_rel", 32'(keys_on), 32'b1111);
`endif

        settle();
        check("scoreboard_empty", 32'(q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
